// File: rtl/adder_bist.sv
// Exhaustive self-test engine for the laca_* lookahead adders: sweeps every
// {c0, n1, n2} vector, checks {carry, sum} against a reference and logs errors.
module adder_bist #(
  parameter int W      = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [W-1:0]       n1,
  output logic [W-1:0]       n2,
  output logic               c0,
  input  logic [W-1:0]       sum,
  input  logic               carry,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [2*W:0]       first_fail
);

  localparam int VW = 2 * W + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]    SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0]    CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1'b1);
  localparam logic [VW-1:0]    VEC_ZERO    = {VW{1'b0}};
  localparam logic [VW-1:0]    VEC_ONE     = VW'(1'b1);
  localparam logic [VW-1:0]    VEC_LAST    = {VW{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1'b1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [VW-1:0]     vec_r;
  logic [CW-1:0]     wait_cnt_r;
  logic              load_s;
  logic              check_s;
  logic              finish_s;
  logic              mismatch_s;
  logic [ERR_W-1:0]  err_nxt_s;

  // Golden model: full-width add, carry-out kept as the MSB.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == ERR_MAX) begin
      r = v;
    end else begin
      r = v + ERR_ONE;
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    check_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt_s = S_APPLY;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_APPLY: begin
        if (SETTLE == 0) begin
          state_nxt_s = S_CHECK;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_r == SETTLE_LAST) begin
          state_nxt_s = S_CHECK;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_CHECK: begin
        check_s = 1'b1;
        if (vec_r == VEC_LAST) begin
          state_nxt_s = S_DONE;
          finish_s    = 1'b1;
        end else begin
          state_nxt_s = S_APPLY;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Result comparison; operands always mirror vec_r during a vector's slot.
  always_comb begin
    mismatch_s = ({carry, sum} != ref_sum(n1, n2, c0));
    if (check_s && mismatch_s) begin
      err_nxt_s = sat_inc(err_cnt);
    end else begin
      err_nxt_s = err_cnt;
    end
  end

  // Sweep datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_r      <= VEC_ZERO;
      wait_cnt_r <= CNT_ZERO;
      n1         <= {W{1'b0}};
      n2         <= {W{1'b0}};
      c0         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= ERR_ZERO;
      first_fail <= VEC_ZERO;
    end else begin
      if (load_s) begin
        vec_r          <= VEC_ZERO;
        {c0, n1, n2}   <= VEC_ZERO;
        err_cnt        <= ERR_ZERO;
        first_fail     <= VEC_ZERO;
        done           <= 1'b0;
        pass           <= 1'b0;
        busy           <= 1'b1;
      end else if (check_s) begin
        err_cnt <= err_nxt_s;
        // err_cnt is still zero only until the first mismatch is logged.
        if (mismatch_s && (err_cnt == ERR_ZERO)) begin
          first_fail <= vec_r;
        end else begin
          first_fail <= first_fail;
        end
        if (finish_s) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt_s == ERR_ZERO);
        end else begin
          vec_r        <= vec_r + VEC_ONE;
          {c0, n1, n2} <= vec_r + VEC_ONE;
        end
      end else begin
        vec_r <= vec_r;
      end

      if (state_r == S_WAIT) begin
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      end else begin
        wait_cnt_r <= CNT_ZERO;
      end
    end
  end

endmodule
